// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: state encoding, the state
// enum built on it, the default board-level timing constants and a small
// state-classification helper.
package pulse_stretch_pkg;

    // Raw state encodings; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] IDLE_ENC = 2'b00;
    localparam logic [1:0] ON_ENC   = 2'b01;
    localparam logic [1:0] GAP_ENC  = 2'b10;

    // Default pulse timing used by the board top.
    localparam int DEF_ON_CYCLES  = 4;
    localparam int DEF_OFF_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_ENC,
        ST_ON   = ON_ENC,
        ST_GAP  = GAP_ENC
    } state_t;

    // True for the states in which a pulse or its trailing gap is running.
    function automatic logic state_active(input state_t s);
        return (s == ST_ON) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// Event/status bundle of the pulse stretcher.
// master: the event source / status consumer; slave: the stretcher itself.
interface pulse_stretch_if #(
    parameter int PEND_W = 4
) ();

    logic              tick_in;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              ovf;

    modport master (
        output tick_in,
        input  level_out,
        input  busy,
        input  pend_cnt,
        input  ovf
    );

    modport slave (
        input  tick_in,
        output level_out,
        output busy,
        output pend_cnt,
        output ovf
    );

endinterface

// File: rtl/pulse_stretch_timer.sv
// stretch_timer: loadable down-counter used to time the ON and GAP phases.
// load has priority over counting; the counter holds at zero rather than
// wrapping, and zero reflects the registered count.
module stretch_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Counter register: reload, count down while enabled, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event ticks into level pulses of
// ON_CYCLES high followed by at least OFF_CYCLES low. Ticks arriving while
// a pulse or gap is running are counted in a saturating pending counter and
// replayed back-to-back; a tick lost to a full counter sets the sticky ovf.
//
// Build option PULSE_STRETCH_RETRIGGER_EN: when defined, a tick during the
// high phase restarts the high timer instead of being queued.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int CNT_W      = 8,
    parameter int PEND_W     = 4
) (
    input  logic           clk,
    input  logic           reset,
    pulse_stretch_if.slave bus
);

    localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0]  OFF_LOAD  = CNT_W'(OFF_CYCLES - 32'sd1);
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(32'd1);

    state_t            state_r;
    state_t            state_next_s;
    logic              level_r;
    logic              busy_r;
    logic [PEND_W-1:0] pend_r;
    logic [PEND_W-1:0] pend_next_s;
    logic              ovf_r;

    logic              pend_nz_s;
    logic              start_s;
    logic              inc_s;
    logic              dec_s;
    logic              drop_s;

    logic              tmr_load_s;
    logic [CNT_W-1:0]  tmr_val_s;
    logic              tmr_en_s;
    logic              tmr_zero_s;

    assign pend_nz_s = (pend_r != PEND_ZERO);
    assign start_s   = bus.tick_in | pend_nz_s;

    stretch_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_en_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, timer control and queue increment/decrement requests.
    // When a start is taken, a queued event is served first and the
    // concurrent tick (if any) takes its place in the queue; a start taken
    // with an empty queue is the tick itself and is not queued.
    always_comb begin
        state_next_s = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = ON_LOAD;
        tmr_en_s     = 1'b0;
        inc_s        = 1'b0;
        dec_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_ON;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = ON_LOAD;
                    inc_s        = bus.tick_in & pend_nz_s;
                    dec_s        = pend_nz_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ON: begin
                tmr_en_s = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (bus.tick_in) begin
                    state_next_s = ST_ON;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = ON_LOAD;
                end else if (tmr_zero_s) begin
                    state_next_s = ST_GAP;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = OFF_LOAD;
                end else begin
                    state_next_s = ST_ON;
                end
`else
                inc_s = bus.tick_in;
                if (tmr_zero_s) begin
                    state_next_s = ST_GAP;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = OFF_LOAD;
                end else begin
                    state_next_s = ST_ON;
                end
`endif
            end
            ST_GAP: begin
                tmr_en_s = 1'b1;
                if (tmr_zero_s && start_s) begin
                    state_next_s = ST_ON;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = ON_LOAD;
                    inc_s        = bus.tick_in & pend_nz_s;
                    dec_s        = pend_nz_s;
                end else if (tmr_zero_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                    inc_s        = bus.tick_in;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pending-counter arithmetic: saturate at full, flag a dropped event.
    // A decrement is only requested with a non-empty queue, so no underflow.
    always_comb begin
        pend_next_s = pend_r;
        drop_s      = 1'b0;
        if (inc_s && !dec_s) begin
            if (pend_r == PEND_MAX) begin
                pend_next_s = pend_r;
                drop_s      = 1'b1;
            end else begin
                pend_next_s = pend_r + PEND_ONE;
            end
        end else if (dec_s && !inc_s) begin
            pend_next_s = pend_r - PEND_ONE;
        end else begin
            pend_next_s = pend_r;
        end
    end

    // State, registered outputs, queue and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            level_r <= 1'b0;
            busy_r  <= 1'b0;
            pend_r  <= PEND_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            level_r <= (state_next_s == ST_ON);
            busy_r  <= state_active(state_next_s);
            pend_r  <= pend_next_s;
            ovf_r   <= ovf_r | drop_s;
        end
    end

    assign bus.level_out = level_r;
    assign bus.busy      = busy_r;
    assign bus.pend_cnt  = pend_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch (ON=4, OFF=2). dut_a uses PEND_W=4,
// dut_b uses PEND_W=2 for the saturation case. Each table row gives, per
// cycle, the tick stimulus and the expected level/busy/pend/ovf as strings
// (one character per cycle, cycle 0 = first cycle after reset release).
module tb_pulse_stretch;

    localparam int NCYC = 40;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    pulse_stretch_if #(.PEND_W(4)) bus_a ();
    pulse_stretch_if #(.PEND_W(2)) bus_b ();

    pulse_stretch #(
        .ON_CYCLES (4),
        .OFF_CYCLES(2),
        .CNT_W     (8),
        .PEND_W    (4)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    pulse_stretch #(
        .ON_CYCLES (4),
        .OFF_CYCLES(2),
        .CNT_W     (8),
        .PEND_W    (2)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    sel_b;
        string tick;
        string lvl;
        string busy;
        string pend;
        string ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int digit(input string s, input int c);
        return int'(s[c]) - 48;
    endfunction

    // Assert reset on a falling edge, check reset state, release two edges later.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus_a.tick_in = 1'b0;
        bus_b.tick_in = 1'b0;
        #1;
        chk("rst.a.level", 0, 32'(bus_a.level_out), 0);
        chk("rst.a.busy",  0, 32'(bus_a.busy), 0);
        chk("rst.a.pend",  0, 32'(bus_a.pend_cnt), 0);
        chk("rst.a.ovf",   0, 32'(bus_a.ovf), 0);
        chk("rst.b.pend",  0, 32'(bus_b.pend_cnt), 0);
        chk("rst.b.ovf",   0, 32'(bus_b.ovf), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] a_lvl, a_busy, a_pend, a_ovf;
        do_reset();
        for (int c = 0; c < NCYC; c++) begin
            if (v.sel_b) begin
                a_lvl  = 32'(bus_b.level_out);
                a_busy = 32'(bus_b.busy);
                a_pend = 32'(bus_b.pend_cnt);
                a_ovf  = 32'(bus_b.ovf);
            end else begin
                a_lvl  = 32'(bus_a.level_out);
                a_busy = 32'(bus_a.busy);
                a_pend = 32'(bus_a.pend_cnt);
                a_ovf  = 32'(bus_a.ovf);
            end
            chk({v.name, ".level"}, c, a_lvl,  32'(digit(v.lvl, c)));
            chk({v.name, ".busy"},  c, a_busy, 32'(digit(v.busy, c)));
            chk({v.name, ".pend"},  c, a_pend, 32'(digit(v.pend, c)));
            chk({v.name, ".ovf"},   c, a_ovf,  32'(digit(v.ovf, c)));
            if (v.sel_b) begin
                bus_b.tick_in = (v.tick[c] == "1");
                bus_a.tick_in = 1'b0;
            end else begin
                bus_a.tick_in = (v.tick[c] == "1");
                bus_b.tick_in = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus_a.tick_in = 1'b0;
        bus_b.tick_in = 1'b0;
    endtask

    initial begin
        string z;
        string o;
        string z40;
        z   = "0000000000";
        o   = "1111111111";
        z40 = {z, z, z, z};

        reset = 1'b1;
        bus_a.tick_in = 1'b0;
        bus_b.tick_in = 1'b0;

        // single tick
        vecs[0] = '{"single", 1'b0, {z, "1000000000", z, z},
                    {z, "0111100000", z, z}, {z, "0111111000", z, z}, z40, z40};
        // tick on the last gap cycle: back-to-back pulse, no idle cycle
        vecs[1] = '{"gapend", 1'b0, {z, "1000001000", z, z},
                    {z, "0111100111", "1000000000", z}, {z, "0111111111", "1110000000", z}, z40, z40};
`ifdef PULSE_STRETCH_RETRIGGER_EN
        vecs[2] = '{"burst3", 1'b0, {z, "1110000000", z, z},
                    {z, "0111111000", z, z}, {z, "0111111110", z, z}, z40, z40};
        vecs[3] = '{"two", 1'b0, {z, "1010000000", z, z},
                    {z, "0111111000", z, z}, {z, "0111111110", z, z}, z40, z40};
        vecs[4] = '{"sat", 1'b1, {z, "1111100000", z, z},
                    {z, "0111111110", z, z}, {z, "0111111111", "1000000000", z}, z40, z40};
`else
        vecs[2] = '{"burst3", 1'b0, {z, "1110000000", z, z},
                    {z, "0111100111", "1001111000", z}, {z, "0111111111", "1111111110", z},
                    {z, "0012222111", "1110000000", z}, z40};
        vecs[3] = '{"two", 1'b0, {z, "1010000000", z, z},
                    {z, "0111100111", "1000000000", z}, {z, "0111111111", "1110000000", z},
                    {z, "0001111000", z, z}, z40};
        vecs[4] = '{"sat", 1'b1, {z, "1111100000", z, z},
                    {z, "0111100111", "1001111001", "1110000000"},
                    {z, "0111111111", o, "1111100000"},
                    {z, "0012333222", "2221111110", z},
                    {z, "0000011111", o, o}};
`endif
        vecs[5] = '{"quiet", 1'b0, z40, z40, z40, z40, z40};

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
`ifndef PULSE_STRETCH_RETRIGGER_EN
            if (i == 4) begin
                // ovf is sticky until reset; a mid-cycle reset clears it at once
                chk("sat.ovf_hold", NCYC, 32'(bus_b.ovf), 1);
                #2;
                reset = 1'b1;
                #1;
                chk("sat.ovf_rst", NCYC, 32'(bus_b.ovf), 0);
                chk("sat.pend_rst", NCYC, 32'(bus_b.pend_cnt), 0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("sat.ovf_after", c, 32'(bus_b.ovf), 0);
                end
            end
`endif
        end

        // Reset in the middle of cycle 12 of the three-tick burst.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus_a.tick_in = (c >= 10);
            @(posedge clk);
            @(negedge clk);
        end
        chk("rstmid.level_pre", 12, 32'(bus_a.level_out), 1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
        chk("rstmid.pend_pre", 12, 32'(bus_a.pend_cnt), 0);
`else
        chk("rstmid.pend_pre", 12, 32'(bus_a.pend_cnt), 1);
`endif
        bus_a.tick_in = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid.level", 12, 32'(bus_a.level_out), 0);
        chk("rstmid.busy",  12, 32'(bus_a.busy), 0);
        chk("rstmid.pend",  12, 32'(bus_a.pend_cnt), 0);
        chk("rstmid.ovf",   12, 32'(bus_a.ovf), 0);
        bus_a.tick_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rstmid.level_after", c, 32'(bus_a.level_out), 0);
            chk("rstmid.busy_after",  c, 32'(bus_a.busy), 0);
            chk("rstmid.pend_after",  c, 32'(bus_a.pend_cnt), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Output-side counterpart of the switch debouncer: turns single-cycle event ticks into clean, human- and hardware-visible level pulses.
- Each pulse has a guaranteed minimum high time, followed by a guaranteed minimum low gap.
- Ticks that arrive while a pulse or gap is in progress are queued and replayed, so no event is lost below the queue limit.
- Sits between datapath/peripheral event sources (e.g. debounced key ticks, UART byte strobes) and LEDs or slow external strobe pins.

Parameters:
- ON_CYCLES, 4, high time of every pulse in clk cycles (>=1).
- OFF_CYCLES, 2, minimum low gap after every pulse in clk cycles (>=1).
- CNT_W, 8, timer width; must satisfy 2^CNT_W > max(ON_CYCLES, OFF_CYCLES).
- PEND_W, 4, width of the pending-tick counter; queue depth is 2^PEND_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- tick_in  in  1  event strobe, sampled every rising clk edge; each high cycle counts as one event.
- level_out  out  1  stretched pulse, registered.
- busy  out  1  high whenever state is not IDLE, registered.
- pend_cnt  out  PEND_W  number of queued, not-yet-emitted events.
- ovf  out  1  sticky flag: an event was dropped because the queue was full.

Behaviour:
- Reset (async, immediate): state=IDLE, timer=0, level_out=0, busy=0, pend_cnt=0, ovf=0.
- Reset mid-pulse aborts the pulse and discards the queue.
- Only reset clears ovf.
- States: IDLE, ON, GAP.
- Start condition: start = tick_in | (pend_cnt!=0).

IDLE:
- On start, go to ON and load timer=ON_CYCLES-1.
- A tick_in taken directly from IDLE does not touch pend_cnt.
- If pend_cnt!=0 and tick_in=1 in the same cycle, the queued event is consumed and the new tick is queued (net pend_cnt unchanged).

ON:
- level_out=1 in every ON cycle; timer decrements each cycle.
- When timer==0, go to GAP and load timer=OFF_CYCLES-1.

GAP:
- level_out=0; timer decrements each cycle.
- When timer==0: if start, go to ON and load ON_CYCLES-1, giving back-to-back period ON_CYCLES+OFF_CYCLES. Otherwise go to IDLE.

Latency and outputs:
- A tick sampled at edge n in IDLE gives level_out=1 during cycles n+1 .. n+ON_CYCLES.
- level_out = (state==ON) and busy = (state!=IDLE), both as registered outputs.

Queue arithmetic:
- pend_next = pend_cnt + inc - dec.
- inc = tick_in while in ON/GAP, or tick_in in any cycle where a queued event is consumed.
- dec = 1 when a start is taken with pend_cnt!=0.
- Saturates at 2^PEND_W-1.
- An inc that would exceed saturation, with no simultaneous dec, is dropped and sets ovf=1 from the next cycle.
- pend_cnt never wraps and never underflows.

Optional Feature:
- Macro: PULSE_STRETCH_RETRIGGER_EN.
- Defined: tick_in during ON reloads timer=ON_CYCLES-1, extending the current pulse. The tick is not queued. Ticks during GAP are still queued.
- Undefined: tick_in during ON is queued like any other tick, giving one pulse per event.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'b00, ON=2'b01, GAP=2'b10; 2'b11 is illegal and recovers to IDLE next cycle.
  - default ON_CYCLES / OFF_CYCLES constants used by the board top.
- One natural sub-module, stretch_timer: a loadable CNT_W down-counter with load, load_val, en, and a zero output. It is instantiated once.
- FSM and queue stay in pulse_stretch.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, PEND_W=4 unless noted):
- Single tick at cycle 10 -> level_out=1 cycles 11-14, 0 from 15; busy=1 cycles 11-16; pend_cnt stays 0; ovf=0.
- Ticks at cycles 10,11,12 -> pulses at cycles 11-14, 17-20, 23-26; pend_cnt=2 after cycle 12, 1 after 16, 0 after 22; busy drops after cycle 28.
- PEND_W=2: tick at cycle 10, then ticks at 11,12,13,14 -> pend_cnt saturates at 3 after cycle 13; the cycle-14 tick is dropped and ovf=1 from cycle 15; exactly 4 pulses are emitted.
- Reset asserted asynchronously at mid-cycle 12 during scenario 2 -> level_out, busy, pend_cnt, ovf drop immediately to 0; no further pulses after release.
- Macro defined, ticks at cycles 10 and 12 -> one pulse, level_out=1 cycles 11-16, pend_cnt=0. Macro undefined, same stimulus -> pulses 11-14 and 17-20.
- Tick arriving on the final GAP cycle (cycle 16 in scenario 1) -> next pulse 17-20 with no IDLE cycle in between; pend_cnt stays 0.
